carrier_loop_filter_fpll: RTL and testbench
===========================================

// Module: carrier_loop_filter_fpll
// PURPOSE
//  Parametrised FLL-assisted 2nd/3rd-order carrier loop filter for the Costas tracking channel.
//  Per epoch it takes a discriminator phase error and frequency error and updates the integrators.
//  It then emits the NCO frequency word and Doppler estimate to the local carrier NCO.
//  FLL-only pull-in runs for a programmable epoch count, then FLL+PLL tracking.
// PARAMETERS
//  ERR_W          13  signed phase/frequency error width
//  COEF_W         32  signed loop coefficient width
//  GUARD_W         4  extra accumulator guard bits; ACC_W = ERR_W+COEF_W+GUARD_W
//  NCO_W          40  output word width
//  OUT_SHIFT      20  arithmetic right shift from accumulator to NCO word
//  LOOP_ORDER      2  2 or 3; 3 adds a second (acceleration) integrator
//  PULLIN_EPOCHS  20  epochs of FLL-only operation after reset/rework (0 = none)
// PORTS
//  iw_Clk_p_g                 in   1       clock
//  iw_Rst_p_g                 in   1       reset, asynchronous, active-high
//  iw_Loop_Filter_ReWork_h    in   1       sync clear of state/integrators/pull-in count
//  iw_PLL_C1/C2/C3            in   COEF_W  signed phase, rate and acceleration gains (C3 unused if order 2)
//  iw_FLL_CF                  in   COEF_W  signed frequency-error gain
//  iw_Err_Valid_h             in   1       error pair valid, one-cycle pulse
//  iw_Phase_Err / iw_Freq_Err in   ERR_W   signed discriminator outputs
//  ow_Ready_h                 out  1       1 when IDLE; input accepted only when high
//  ow_Overrun_h               out  1       one-cycle pulse: valid arrived while busy (input dropped)
//  ow_Carrier_Loop_Output_Valid out 1      one-cycle pulse with new output
//  ow_Carrier_Loop_Output     out  NCO_W   NCO frequency word
//  ow_Carrier_Doppler         out  NCO_W   rate integrator >>> OUT_SHIFT
//  ow_Pull_In_Done_h          out  1       1 once PULLIN_EPOCHS epochs completed
//  ow_Sat_Flag_h              out  1       sticky saturation indicator (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0, except ow_Ready_h=1. ow_Pull_In_Done_h=1 at reset only if PULLIN_EPOCHS=0.
//   Reset also clears integrators, pull-in count and state=IDLE.
//  ReWork: same clear as reset, synchronous. It has priority over valid and aborts any in-flight epoch (no output pulse).
//  FSM IDLE->MUL->INT->OUT->IDLE, one cycle each. Valid in cycle T (IDLE) is registered.
//   T+1 MUL: p1=pe*C1, p2=pe*C2, p3=pe*C3, pf=fe*CF (full-precision signed, sign-extended to ACC_W).
//   Pull-in active (count<PULLIN_EPOCHS): p1, p2, p3 forced 0.
//   T+2 INT: order 3: a_acc+=p3; w_acc+=p2+pf+a_acc(new). Order 2: w_acc+=p2+pf.
//    Pull-in count increments and saturates at PULLIN_EPOCHS.
//   T+3 OUT: Output=(w_acc+p1)>>>OUT_SHIFT, Doppler=w_acc>>>OUT_SHIFT, both truncated to low NCO_W bits.
//    Valid pulse in this cycle; state IDLE next, so a new valid is accepted at T+4.
//  Latency 3 cycles valid-in to valid-out; max rate 1 epoch / 4 cycles.
//  Valid while ow_Ready_h=0: input ignored, ow_Overrun_h pulses same cycle, epoch unaffected.
//  Outputs hold between pulses; ow_Pull_In_Done_h rises in the INT cycle of the last pull-in epoch.
// CONFIGURATION
//  CLF_SATURATION_EN defined: a_acc, w_acc and pre-shift output sum clamp to +/-(2^(ACC_W-1)-1).
//   Any clamp sets ow_Sat_Flag_h, cleared only by reset/rework.
//  Undefined: two's-complement wrap; ow_Sat_Flag_h tied 0.
// TESTING
//  1 Reset mid-epoch (assert at T+2): all outputs 0, Ready=1, no valid pulse, next epoch starts from cleared integrators.
//  2 PULLIN_EPOCHS=2, C1=2^20, C2=0, CF=0, pe=100: first 2 outputs 0, 3rd output 100, Pull_In_Done after epoch 2.
//  3 PULLIN=0, C1=0, C2=2^20, pe=1 for 5 epochs: outputs 1,2,3,4,5; Doppler equals output; valid 3 cycles after each input.
//  4 ORDER 3, C3=2^20, C1=C2=0, pe=1: outputs 1,3,6,10 (quadratic growth).
//  5 Valid at T and T+2: second dropped, Overrun pulse at T+2, only one output; valid at T+4 accepted.
//  6 Saturation, C2=2^31-1, pe=4095 repeated: with CLF_SATURATION_EN accumulators clamp at max, Sat_Flag=1.
//   Without it, values wrap negative and Sat_Flag stays 0.

Source files
------------

// File: rtl/carrier_loop_filter_fpll.sv
// FLL-assisted 2nd/3rd-order carrier loop filter: one epoch per error pair, four-cycle FSM.
// Optional macro CLF_SATURATION_EN clamps integrators and the output sum instead of wrapping.
module carrier_loop_filter_fpll #(
  parameter int unsigned ERR_W         = 13,
  parameter int unsigned COEF_W        = 32,
  parameter int unsigned GUARD_W       = 4,
  parameter int unsigned NCO_W         = 40,
  parameter int unsigned OUT_SHIFT     = 20,
  parameter int unsigned LOOP_ORDER    = 2,
  parameter int unsigned PULLIN_EPOCHS = 20
) (
  input  logic                     iw_Clk_p_g,
  input  logic                     iw_Rst_p_g,
  input  logic                     iw_Loop_Filter_ReWork_h,
  input  logic signed [COEF_W-1:0] iw_PLL_C1,
  input  logic signed [COEF_W-1:0] iw_PLL_C2,
  input  logic signed [COEF_W-1:0] iw_PLL_C3,
  input  logic signed [COEF_W-1:0] iw_FLL_CF,
  input  logic                     iw_Err_Valid_h,
  input  logic signed [ERR_W-1:0]  iw_Phase_Err,
  input  logic signed [ERR_W-1:0]  iw_Freq_Err,
  output logic                     ow_Ready_h,
  output logic                     ow_Overrun_h,
  output logic                     ow_Carrier_Loop_Output_Valid,
  output logic [NCO_W-1:0]         ow_Carrier_Loop_Output,
  output logic [NCO_W-1:0]         ow_Carrier_Doppler,
  output logic                     ow_Pull_In_Done_h,
  output logic                     ow_Sat_Flag_h
);

  localparam int unsigned ACC_W = ERR_W + COEF_W + GUARD_W;
  // Two extra bits hold the sum of up to four ACC_W terms without overflow.
  localparam int unsigned SUM_W = ACC_W + 2;
  localparam int unsigned CNT_W = (PULLIN_EPOCHS > 0) ? $clog2(PULLIN_EPOCHS + 1) : 1;
  localparam logic [CNT_W-1:0] PULLIN_C = CNT_W'(PULLIN_EPOCHS);
  localparam logic signed [SUM_W-1:0] ACC_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN = -ACC_MAX;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StInt  = 2'd2;
  localparam logic [1:0] StOut  = 2'd3;

  logic [1:0]               state_q, state_d;
  logic signed [ERR_W-1:0]  pe_q, pe_d, fe_q, fe_d;
  logic signed [ACC_W-1:0]  p1_q, p1_d, p2_q, p2_d, p3_q, p3_d, pf_q, pf_d;
  logic signed [ACC_W-1:0]  a_acc_q, a_acc_d, w_acc_q, w_acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NCO_W-1:0]         out_q, out_d, dop_q, dop_d;
  logic                     sat_q, sat_d;

  logic signed [ACC_W-1:0]  pe_x, fe_x, c1_x, c2_x, c3_x, cf_x;
  logic signed [ACC_W-1:0]  a_new, w_new, o_sum, out_sh, dop_sh;
  logic signed [SUM_W-1:0]  a_term;
  logic                     clip_a, clip_w, clip_o, pullin_active;

  function automatic logic signed [SUM_W-1:0] sx(input logic signed [ACC_W-1:0] v);
    return {{(SUM_W-ACC_W){v[ACC_W-1]}}, v};
  endfunction

  function automatic logic signed [ACC_W-1:0] fit(input logic signed [SUM_W-1:0] v,
                                                  output logic clip);
    clip = 1'b0;
`ifdef CLF_SATURATION_EN
    if (v > ACC_MAX) begin
      clip = 1'b1;
      return ACC_MAX[ACC_W-1:0];
    end else if (v < ACC_MIN) begin
      clip = 1'b1;
      return ACC_MIN[ACC_W-1:0];
    end
`endif
    return v[ACC_W-1:0];
  endfunction

  // Products are exact in ACC_W, so ACC_W-wide operands need no wider result.
  assign pe_x = {{(ACC_W-ERR_W){pe_q[ERR_W-1]}}, pe_q};
  assign fe_x = {{(ACC_W-ERR_W){fe_q[ERR_W-1]}}, fe_q};
  assign c1_x = {{(ACC_W-COEF_W){iw_PLL_C1[COEF_W-1]}}, iw_PLL_C1};
  assign c2_x = {{(ACC_W-COEF_W){iw_PLL_C2[COEF_W-1]}}, iw_PLL_C2};
  assign c3_x = {{(ACC_W-COEF_W){iw_PLL_C3[COEF_W-1]}}, iw_PLL_C3};
  assign cf_x = {{(ACC_W-COEF_W){iw_FLL_CF[COEF_W-1]}}, iw_FLL_CF};
  assign pullin_active = cnt_q < PULLIN_C;

  always_comb begin
    state_d = state_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    p3_d    = p3_q;
    pf_d    = pf_q;
    a_acc_d = a_acc_q;
    w_acc_d = w_acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    dop_d   = dop_q;
    sat_d   = sat_q;

    a_new  = fit(sx(a_acc_q) + sx(p3_q), clip_a);
    a_term = (LOOP_ORDER == 3) ? sx(a_new) : {SUM_W{1'b0}};
    w_new  = fit(sx(w_acc_q) + sx(p2_q) + sx(pf_q) + a_term, clip_w);
    o_sum  = fit(sx(w_new) + sx(p1_q), clip_o);
    out_sh = o_sum >>> OUT_SHIFT;
    dop_sh = w_new >>> OUT_SHIFT;

    unique case (state_q)
      StIdle: begin
        if (iw_Err_Valid_h) begin
          pe_d    = iw_Phase_Err;
          fe_d    = iw_Freq_Err;
          state_d = StMul;
        end
      end
      StMul: begin
        p1_d    = pullin_active ? '0 : pe_x * c1_x;
        p2_d    = pullin_active ? '0 : pe_x * c2_x;
        p3_d    = pullin_active ? '0 : pe_x * c3_x;
        pf_d    = fe_x * cf_x;
        state_d = StInt;
      end
      StInt: begin
        a_acc_d = (LOOP_ORDER == 3) ? a_new : '0;
        w_acc_d = w_new;
        if (pullin_active) cnt_d = cnt_q + 1'b1;
        out_d   = NCO_W'(out_sh);
        dop_d   = NCO_W'(dop_sh);
        sat_d   = sat_q | clip_w | clip_o | ((LOOP_ORDER == 3) & clip_a);
        state_d = StOut;
      end
      default: state_d = StIdle;
    endcase

    if (iw_Loop_Filter_ReWork_h) begin
      state_d = StIdle;
      p1_d    = '0;
      p2_d    = '0;
      p3_d    = '0;
      pf_d    = '0;
      a_acc_d = '0;
      w_acc_d = '0;
      cnt_d   = '0;
      out_d   = '0;
      dop_d   = '0;
      sat_d   = 1'b0;
    end
  end

  always_ff @(posedge iw_Clk_p_g or posedge iw_Rst_p_g) begin
    if (iw_Rst_p_g) begin
      state_q <= StIdle;
      pe_q    <= '0;
      fe_q    <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      p3_q    <= '0;
      pf_q    <= '0;
      a_acc_q <= '0;
      w_acc_q <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      dop_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      p3_q    <= p3_d;
      pf_q    <= pf_d;
      a_acc_q <= a_acc_d;
      w_acc_q <= w_acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      dop_q   <= dop_d;
      sat_q   <= sat_d;
    end
  end

  assign ow_Ready_h                   = (state_q == StIdle);
  assign ow_Overrun_h                 = iw_Err_Valid_h & ~ow_Ready_h & ~iw_Loop_Filter_ReWork_h;
  assign ow_Carrier_Loop_Output_Valid = (state_q == StOut) & ~iw_Loop_Filter_ReWork_h;
  assign ow_Carrier_Loop_Output       = out_q;
  assign ow_Carrier_Doppler           = dop_q;
  // Done is visible already in the INT cycle of the final pull-in epoch.
  assign ow_Pull_In_Done_h = (cnt_q == PULLIN_C) |
                             ((state_q == StInt) & ~iw_Loop_Filter_ReWork_h &
                              (cnt_q == PULLIN_C - 1'b1));
  assign ow_Sat_Flag_h = sat_q;

endmodule

// File: tb/tb_carrier_loop_filter_fpll.sv
// Bench for carrier_loop_filter_fpll: three instances (pull-in 2 / order 2, pull-in 0 / order 2,
// pull-in 0 / order 3) share one stimulus stream and are each checked every cycle against a model.
module tb_carrier_loop_filter_fpll;

  localparam longint AMAX = 64'sd281474976710655;

  logic clk = 1'b0;
  logic rst, rework, vld;
  logic signed [31:0] c1, c2, c3, cf;
  logic signed [12:0] pe_in, fe_in;

  logic        rdy_w [3];
  logic        ovr_w [3];
  logic        vo_w  [3];
  logic [39:0] out_w [3];
  logic [39:0] dop_w [3];
  logic        done_w[3];
  logic        sat_w [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    carrier_loop_filter_fpll #(
      .LOOP_ORDER   ((g == 2) ? 3 : 2),
      .PULLIN_EPOCHS((g == 0) ? 2 : 0)
    ) u_dut (
      .iw_Clk_p_g                  (clk),
      .iw_Rst_p_g                  (rst),
      .iw_Loop_Filter_ReWork_h     (rework),
      .iw_PLL_C1                   (c1),
      .iw_PLL_C2                   (c2),
      .iw_PLL_C3                   (c3),
      .iw_FLL_CF                   (cf),
      .iw_Err_Valid_h              (vld),
      .iw_Phase_Err                (pe_in),
      .iw_Freq_Err                 (fe_in),
      .ow_Ready_h                  (rdy_w[g]),
      .ow_Overrun_h                (ovr_w[g]),
      .ow_Carrier_Loop_Output_Valid(vo_w[g]),
      .ow_Carrier_Loop_Output      (out_w[g]),
      .ow_Carrier_Doppler          (dop_w[g]),
      .ow_Pull_In_Done_h           (done_w[g]),
      .ow_Sat_Flag_h               (sat_w[g])
    );
  end

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  // Model state
  longint      w_m[3], a_m[3];
  int          cnt_m[3];
  logic [39:0] out_h[3], dop_h[3], pend_out[3], pend_dop[3];
  logic        done_prev[3], done_new[3], sat_prev[3], sat_new[3];
  int          busy_from, busy_until, exp_vcyc, acc_cyc;

  // Observations for literal checks
  logic [39:0] last_out[3], last_dop[3];
  int          vcnt[3], ocnt[3];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pp(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int ordr(input int i);
    return (i == 2) ? 3 : 2;
  endfunction

  function automatic longint fix(input longint x, output logic c);
    c = 1'b0;
`ifdef CLF_SATURATION_EN
    if (x > AMAX) begin x = AMAX; c = 1'b1; end
    else if (x < -AMAX) begin x = -AMAX; c = 1'b1; end
`else
    x = (x <<< 15) >>> 15;
`endif
    return x;
  endfunction

  task automatic chk(input string nm, input longint got, input longint exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      w_m[i] = 0; a_m[i] = 0; cnt_m[i] = 0;
      out_h[i] = '0; dop_h[i] = '0;
      done_prev[i] = (pp(i) == 0); done_new[i] = (pp(i) == 0);
      sat_prev[i] = 1'b0; sat_new[i] = 1'b0;
    end
    busy_from = 1; busy_until = 0; exp_vcyc = -1; acc_cyc = -10;
  endtask

  function automatic logic ready_exp(input int c);
    return !(c >= busy_from && c <= busy_until);
  endfunction

  task automatic model_epoch(input int i);
    longint pe, fe, p1, p2, p3, pf, t;
    logic act, ca, cw, co;
    pe = pe_in; fe = fe_in;
    act = cnt_m[i] < pp(i);
    p1 = act ? 0 : pe * longint'(c1);
    p2 = act ? 0 : pe * longint'(c2);
    p3 = act ? 0 : pe * longint'(c3);
    pf = fe * longint'(cf);
    ca = 1'b0;
    if (ordr(i) == 3) begin
      a_m[i] = fix(a_m[i] + p3, ca);
      w_m[i] = fix(w_m[i] + p2 + pf + a_m[i], cw);
    end else begin
      w_m[i] = fix(w_m[i] + p2 + pf, cw);
    end
    t = fix(w_m[i] + p1, co);
    t = t >>> 20;
    pend_out[i] = t[39:0];
    t = w_m[i] >>> 20;
    pend_dop[i] = t[39:0];
    if (cnt_m[i] < pp(i)) cnt_m[i]++;
    done_prev[i] = done_new[i];
    done_new[i]  = cnt_m[i] >= pp(i);
    sat_prev[i]  = sat_new[i];
    sat_new[i]   = sat_new[i] | ca | cw | co;
  endtask

  // One-cycle valid pulse; accepted only if the model says the filter is idle.
  task automatic send(input int pe, input int fe);
    pe_in = 13'(pe);
    fe_in = 13'(fe);
    vld   = 1'b1;
    if (ready_exp(cyc)) begin
      for (int i = 0; i < 3; i++) model_epoch(i);
      acc_cyc = cyc; busy_from = cyc + 1; busy_until = cyc + 3; exp_vcyc = cyc + 3;
    end
    @(posedge clk); #1;
    vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic epoch(input int pe, input int fe);
    send(pe, fe);
    idle(3);
  endtask

  task automatic do_rework();
    rework = 1'b1;
    @(posedge clk); #1;
    rework = 1'b0;
    clear_model();
  endtask

  task automatic set_coef(input longint a, input longint b, input longint c, input longint f);
    c1 = 32'(a); c2 = 32'(b); c3 = 32'(c); cf = 32'(f);
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (cyc == exp_vcyc)
      for (int i = 0; i < 3; i++) begin out_h[i] = pend_out[i]; dop_h[i] = pend_dop[i]; end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("valid[%0d]", i), longint'(vo_w[i]), longint'(cyc == exp_vcyc));
      chk($sformatf("ready[%0d]", i), longint'(rdy_w[i]), longint'(ready_exp(cyc)));
      chk($sformatf("overrun[%0d]", i), longint'(ovr_w[i]),
          longint'(vld && !ready_exp(cyc) && !rework));
      chk($sformatf("output[%0d]", i), longint'(out_w[i]), longint'(out_h[i]));
      chk($sformatf("doppler[%0d]", i), longint'(dop_w[i]), longint'(dop_h[i]));
      chk($sformatf("pullin_done[%0d]", i), longint'(done_w[i]),
          longint'((cyc >= acc_cyc + 2) ? done_new[i] : done_prev[i]));
      chk($sformatf("sat_flag[%0d]", i), longint'(sat_w[i]),
          longint'((cyc >= acc_cyc + 3) ? sat_new[i] : sat_prev[i]));
      if (vo_w[i]) begin last_out[i] = out_w[i]; last_dop[i] = dop_w[i]; vcnt[i]++; end
      if (ovr_w[i]) ocnt[i]++;
    end
  end

  initial begin
    int v0;
    for (int i = 0; i < 3; i++) begin vcnt[i] = 0; ocnt[i] = 0; last_out[i] = '0; last_dop[i] = '0; end
    rst = 1'b1; rework = 1'b0; vld = 1'b0; pe_in = '0; fe_in = '0;
    set_coef(0, 0, 0, 0);
    clear_model();
    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset state
    chk("reset_ready", longint'(rdy_w[0]), 1);
    chk("reset_done_pullin2", longint'(done_w[0]), 0);
    chk("reset_done_pullin0", longint'(done_w[1]), 1);
    chk("reset_output", longint'(out_w[1]), 0);

    // Pull-in of 2 epochs forces the PLL path off on instance 0
    do_rework();
    set_coef(64'd1 << 20, 0, 0, 0);
    epoch(100, 0);
    chk("pullin_ep1_out", longint'(last_out[0]), 0);
    chk("pullin_ep1_done", longint'(done_w[0]), 0);
    epoch(100, 0);
    chk("pullin_ep2_out", longint'(last_out[0]), 0);
    chk("pullin_ep2_done", longint'(done_w[0]), 1);
    epoch(100, 0);
    chk("pullin_ep3_out", longint'(last_out[0]), 100);
    chk("nopullin_out", longint'(last_out[1]), 100);

    // Rate integrator ramp
    do_rework();
    set_coef(0, 64'd1 << 20, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      epoch(1, 0);
      chk($sformatf("ramp_out_%0d", k), longint'(last_out[1]), k);
      chk($sformatf("ramp_dop_%0d", k), longint'(last_dop[1]), k);
    end

    // Third-order quadratic growth
    do_rework();
    set_coef(0, 0, 64'd1 << 20, 0);
    epoch(1, 0); chk("order3_1", longint'(last_out[2]), 1);
    epoch(1, 0); chk("order3_2", longint'(last_out[2]), 3);
    epoch(1, 0); chk("order3_3", longint'(last_out[2]), 6);
    epoch(1, 0); chk("order3_4", longint'(last_out[2]), 10);

    // Valid while busy is dropped with an overrun pulse
    do_rework();
    set_coef(0, 64'd1 << 20, 0, 0);
    v0 = vcnt[1];
    send(7, 0); idle(1);
    send(9, 0); idle(1);
    chk("overrun_count", longint'(ocnt[1]), 1);
    send(1, 0); idle(3);
    chk("overrun_pulses", longint'(vcnt[1] - v0), 2);
    chk("overrun_out", longint'(last_out[1]), 8);

    // Asynchronous reset in the INT cycle aborts the epoch
    v0 = vcnt[1];
    send(5, 0); idle(1);
    rst = 1'b1;
    clear_model();
    idle(2);
    rst = 1'b0;
    idle(1);
    chk("midreset_no_pulse", longint'(vcnt[1] - v0), 0);
    epoch(1, 0);
    chk("midreset_fresh_out", longint'(last_out[1]), 1);

    // FLL path stays live during pull-in
    do_rework();
    set_coef(0, 0, 0, 64'd1 << 20);
    epoch(0, 3);
    chk("fll_pullin_out", longint'(last_out[0]), 3);

    // Saturation / wrap at the accumulator limit after 33 full-scale epochs
    do_rework();
    set_coef(0, 64'd2147483647, 0, 0);
    for (int k = 0; k < 33; k++) epoch(4095, 0);
`ifdef CLF_SATURATION_EN
    chk("sat_dop", longint'(last_dop[1]), 268435455);
    chk("sat_out", longint'(last_out[1]), 268435455);
    chk("sat_flag", longint'(sat_w[1]), 1);
`else
    chk("wrap_sign", longint'(last_dop[1][39]), 1);
    chk("wrap_flag", longint'(sat_w[1]), 0);
`endif
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
